// File: rtl/local_inject_arbiter_if.sv
// Flit types and the requester/router handshake bundle for local_inject_arbiter.
// The arbiter connects to the slave modport; requesters and the router drive the master side.
package local_inject_arbiter_pkg;
    localparam int unsigned VC_PER_PORT = 2;
    localparam int unsigned VC_W        = 1;
    localparam int unsigned DATA_W      = 16;

    typedef enum logic [1:0] {
        HEADER = 2'b00,
        BODY   = 2'b01,
        TAIL   = 2'b10,
        HT     = 2'b11
    } flit_type_t;

    typedef struct packed {
        flit_type_t        flit_type;
        logic [VC_W-1:0]   vc_id;
        logic [DATA_W-1:0] data;
    } flit_t;
endpackage

interface local_inject_arbiter_if #(
    parameter int unsigned REQ_NUM = 4
);
    import local_inject_arbiter_pkg::*;

    logic [REQ_NUM-1:0]     req_valid;
    flit_t [REQ_NUM-1:0]    req_flit;
    logic [REQ_NUM-1:0]     req_ready;
    logic [VC_PER_PORT-1:0] on_off_in;
    logic                   wr_en_out;
    flit_t                  flit_out;

    modport master (
        output req_valid, req_flit, on_off_in,
        input  req_ready, wr_en_out, flit_out
    );

    modport slave (
        input  req_valid, req_flit, on_off_in,
        output req_ready, wr_en_out, flit_out
    );
endinterface

// File: rtl/local_inject_arbiter.sv
// Round-robin arbiter for the router local injection port, holding a lock for whole packets.
// Optional stall watchdog compiled in with INJ_ARB_WATCHDOG_EN.
module local_inject_arbiter
    import local_inject_arbiter_pkg::*;
#(
    parameter int unsigned REQ_NUM    = 4,
    parameter int unsigned WDOG_LIMIT = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    local_inject_arbiter_if.slave      bus,
    output logic                       busy,
    output logic [$clog2(REQ_NUM)-1:0] owner_id,
    output logic                       wdog_error
);
    localparam int unsigned PTR_W = $clog2(REQ_NUM);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr, rr_nxt, owner_nxt, winner;
    logic               found, accept;
    logic [REQ_NUM-1:0] eligible, ready;
    flit_t              acc_flit;

    function automatic logic [PTR_W-1:0] inc_mod(input logic [PTR_W-1:0] v);
        return (v == PTR_W'(REQ_NUM - 1)) ? '0 : v + 1'b1;
    endfunction

    // Only packet starts may win arbitration; BODY/TAIL in IDLE are held forever.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < REQ_NUM; i++) begin
            eligible[i] = bus.req_valid[i]
                       && (bus.req_flit[i].flit_type == HEADER || bus.req_flit[i].flit_type == HT)
                       && bus.on_off_in[bus.req_flit[i].vc_id];
        end
    end

    always_comb begin
        int unsigned idx;
        idx       = 0;
        state_nxt = state;
        rr_nxt    = rr_ptr;
        owner_nxt = owner_id;
        ready     = '0;
        found     = 1'b0;
        winner    = '0;
        if (enable) begin
            case (state)
                IDLE: begin
                    for (int unsigned k = 0; k < REQ_NUM; k++) begin
                        idx = (32'(rr_ptr) + k) % REQ_NUM;
                        if (!found && eligible[idx]) begin
                            found  = 1'b1;
                            winner = PTR_W'(idx);
                        end
                    end
                    if (found) begin
                        ready[winner] = 1'b1;
                        if (bus.req_flit[winner].flit_type == HT) begin
                            rr_nxt = inc_mod(winner);
                        end else begin
                            state_nxt = LOCKED;
                            owner_nxt = winner;
                        end
                    end
                end
                LOCKED: begin
                    ready[owner_id] = bus.req_valid[owner_id]
                                   && bus.on_off_in[bus.req_flit[owner_id].vc_id];
                    if (ready[owner_id] && bus.req_flit[owner_id].flit_type == TAIL) begin
                        state_nxt = IDLE;
                        rr_nxt    = inc_mod(owner_id);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
        accept   = |ready;
        acc_flit = bus.req_flit[(state == IDLE) ? winner : owner_id];
    end

    assign bus.req_ready = ready;
    assign busy          = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            owner_id      <= '0;
            bus.wr_en_out <= 1'b0;
            bus.flit_out  <= '0;
        end else begin
            state         <= state_nxt;
            rr_ptr        <= rr_nxt;
            owner_id      <= owner_nxt;
            bus.wr_en_out <= accept;
            if (accept) begin
                bus.flit_out <= acc_flit;
            end
        end
    end

`ifdef INJ_ARB_WATCHDOG_EN
    localparam logic [15:0] WDOG_LIM = 16'(WDOG_LIMIT);

    logic [15:0] wdog_cnt;

    // Counter saturates at the limit; the error flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_cnt   <= '0;
            wdog_error <= 1'b0;
        end else if (enable) begin
            if (state == LOCKED && state_nxt == LOCKED && !accept) begin
                if (wdog_cnt < WDOG_LIM) begin
                    wdog_cnt <= wdog_cnt + 1'b1;
                end
                if (wdog_cnt >= WDOG_LIM - 1'b1) begin
                    wdog_error <= 1'b1;
                end
            end else begin
                wdog_cnt <= '0;
            end
        end
    end
`else
    assign wdog_error = 1'b0;
`endif

endmodule

// File: tb/tb_local_inject_arbiter.sv
// Scoreboard bench for local_inject_arbiter: expected flits queued at stimulus time,
// a negedge monitor pops and compares whenever wr_en_out is high.
module tb_local_inject_arbiter;
    import local_inject_arbiter_pkg::*;

    localparam int unsigned N = 4;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       busy;
    logic [1:0] owner_id;
    logic       wdog_error;

    int unsigned vectors = 0;
    int unsigned errors  = 0;

    flit_t exp_q[$];
    flit_t rq[N][$];
    logic [N-1:0] hs;

    local_inject_arbiter_if #(.REQ_NUM(N)) bus ();

    local_inject_arbiter #(.REQ_NUM(N), .WDOG_LIMIT(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .bus        (bus),
        .busy       (busy),
        .owner_id   (owner_id),
        .wdog_error (wdog_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    function automatic flit_t mk(input flit_type_t t, input logic vc, input logic [15:0] d);
        flit_t f;
        f.flit_type = t;
        f.vc_id     = vc;
        f.data      = d;
        return f;
    endfunction

    // Requester driver: presents each queue head, pops it after a handshake.
    initial begin
        bus.req_valid = '0;
        bus.req_flit  = '0;
        hs            = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++)
                hs[i] = !reset && bus.req_valid[i] && bus.req_ready[i];
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (hs[i] && rq[i].size() != 0) void'(rq[i].pop_front());
                if (rq[i].size() != 0) begin
                    bus.req_valid[i] = 1'b1;
                    bus.req_flit[i]  = rq[i][0];
                end else begin
                    bus.req_valid[i] = 1'b0;
                end
            end
        end
    end

    // Output monitor / scoreboard.
    always @(negedge clk) begin
        if (bus.wr_en_out === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL flit_out_unexpected: got %h, required no output", bus.flit_out);
            end else begin
                flit_t e;
                e = exp_q.pop_front();
                if (bus.flit_out !== e) begin
                    errors++;
                    $display("FAIL flit_out: got %h, required %h", bus.flit_out, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push(input int i, input flit_t f, input bit expect_out);
        rq[i].push_back(f);
        if (expect_out) exp_q.push_back(f);
    endtask

    task automatic wait_hs(input int i);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.req_valid[i] && bus.req_ready[i]) && n < 50);
        vectors++;
        if (!(bus.req_valid[i] && bus.req_ready[i])) begin
            errors++;
            $display("FAIL handshake_timeout req%0d: got no handshake, required one", i);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drain", exp_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        reset         = 1'b1;
        enable        = 1'b1;
        bus.on_off_in = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wr_en", bus.wr_en_out, 0);
        check("rst_flit_out", bus.flit_out, 0);
        check("rst_busy", busy, 0);
        check("rst_owner", owner_id, 0);
        check("rst_wdog", wdog_error, 0);

        // Two HT flits: 0 then 2, written on the 2nd and 3rd cycle after release.
        push(0, mk(HT, 1'b0, 16'h0a01), 1);
        push(2, mk(HT, 1'b0, 16'h0a02), 1);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("ht_wr_en_timing", bus.wr_en_out, (k == 1 || k == 2) ? 1 : 0);
        end
        drain();

        // Packet from 1 while 3 waits with a HEADER.
        push(1, mk(HEADER, 1'b0, 16'h1100), 1);
        push(1, mk(BODY,   1'b0, 16'h1101), 1);
        push(1, mk(TAIL,   1'b0, 16'h1102), 1);
        wait_hs(1);
        push(3, mk(HEADER, 1'b0, 16'h3100), 1);
        push(3, mk(TAIL,   1'b0, 16'h3101), 1);
        wait_hs(1);
        check("lock_ready3_body", bus.req_ready[3], 0);
        check("lock_busy", busy, 1);
        check("lock_owner", owner_id, 1);
        wait_hs(1);
        check("lock_ready3_tail", bus.req_ready[3], 0);
        @(negedge clk);
        check("after_tail_ready3", bus.req_ready[3], 1);
        check("after_tail_busy", busy, 0);
        drain();

        // VC1 off for 5 cycles mid-packet; requester 2 must not get in.
        push(0, mk(HEADER, 1'b1, 16'h0500), 1);
        push(0, mk(BODY,   1'b1, 16'h0501), 1);
        push(0, mk(TAIL,   1'b1, 16'h0502), 1);
        push(2, mk(HT,     1'b0, 16'h2500), 1);
        wait_hs(0);
        @(posedge clk);
        #1 bus.on_off_in = 2'b01;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("vc_stall_ready", bus.req_ready, 0);
            check("vc_stall_busy", busy, 1);
        end
        @(posedge clk);
        #1 bus.on_off_in = '1;
        drain();

        // BODY in IDLE is never accepted.
        push(1, mk(BODY, 1'b0, 16'h1600), 0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("idle_body_ready", bus.req_ready[1], 0);
            check("idle_body_wr_en", bus.wr_en_out, 0);
        end
        rq[1].delete();
        @(negedge clk);

        // Owner stalled 10 cycles after its HEADER.
        push(3, mk(HEADER, 1'b0, 16'h3700), 1);
        push(3, mk(BODY,   1'b0, 16'h3701), 1);
        push(3, mk(TAIL,   1'b0, 16'h3702), 1);
        wait_hs(3);
        @(posedge clk);
        #1 bus.on_off_in = '0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check("wdog_stall_busy", busy, 1);
`ifdef INJ_ARB_WATCHDOG_EN
            check("wdog_stall_flag", wdog_error, (k >= 9) ? 1 : 0);
`else
            check("wdog_stall_flag", wdog_error, 0);
`endif
        end
        @(posedge clk);
        #1 bus.on_off_in = '1;
        drain();
`ifdef INJ_ARB_WATCHDOG_EN
        check("wdog_sticky", wdog_error, 1);
`else
        check("wdog_sticky", wdog_error, 0);
`endif

        // Reset mid-packet: rr_ptr moved to 2 beforehand, owner 2.
        push(1, mk(HT, 1'b0, 16'h1800), 1);
        wait_hs(1);
        push(2, mk(HEADER, 1'b0, 16'h2800), 1);
        push(2, mk(BODY,   1'b0, 16'h2801), 1);
        push(2, mk(BODY,   1'b0, 16'h2802), 0);
        push(2, mk(TAIL,   1'b0, 16'h2803), 0);
        wait_hs(2);
        wait_hs(2);
        check("pre_reset_owner", owner_id, 2);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_reset_busy", busy, 0);
        check("mid_reset_wr_en", bus.wr_en_out, 0);
        check("mid_reset_owner", owner_id, 0);
        check("mid_reset_wdog", wdog_error, 0);
        check("mid_reset_ready", bus.req_ready, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_reset_body_ready", bus.req_ready[2], 0);
            check("post_reset_wr_en", bus.wr_en_out, 0);
        end
        rq[2].delete();
        push(3, mk(HT, 1'b0, 16'h3801), 0);
        push(0, mk(HT, 1'b0, 16'h0801), 0);
        exp_q.push_back(mk(HT, 1'b0, 16'h0801));
        exp_q.push_back(mk(HT, 1'b0, 16'h3801));
        drain();

        // enable low: no ready, no write, then the flit goes through.
        enable = 1'b0;
        push(1, mk(HT, 1'b0, 16'h1900), 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("disable_ready", bus.req_ready, 0);
            check("disable_wr_en", bus.wr_en_out, 0);
        end
        @(posedge clk);
        #1 enable = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/local_inject_arbiter.md
LOCAL_INJECT_ARBITER -- requirements
Module: local_inject_arbiter

Interface
REQ-001 Parameter REQ_NUM, default 4, number of requesters sharing the router local (port 0) injection port; legal range 2..16.
REQ-002 Parameter WDOG_LIMIT, default 255, consecutive stalled LOCKED cycles before the watchdog fires; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  when low, no flit is accepted and all state is held.
REQ-006 req_valid  input  REQ_NUM  requester i presents a flit.
REQ-007 req_flit  input  flit_t[REQ_NUM]  flit offered by requester i; fields flit_type and vc_id are used.
REQ-008 req_ready  output  REQ_NUM  combinational; flit i is consumed in this cycle when req_valid[i] & req_ready[i].
REQ-009 on_off_in  input  VC_PER_PORT  router local-port on/off flow control; 1 means the VC may receive.
REQ-010 wr_en_out  output  1  registered write enable to router local input.
REQ-011 flit_out  output  flit_t  registered flit to router local input.
REQ-012 busy  output  1  high while in LOCKED.
REQ-013 owner_id  output  $clog2(REQ_NUM)  current or last packet owner.
REQ-014 wdog_error  output  1  sticky watchdog flag.

Function
REQ-015 FSM states IDLE and LOCKED.
REQ-016 Eligible in IDLE: req_valid[i] & flit_type in {HEADER, HT} & on_off_in[req_flit[i].vc_id].
REQ-017 IDLE with enable: grant the first eligible requester in round-robin order starting at rr_ptr; req_ready is high only for that requester, in the same cycle.
REQ-018 IDLE grant of an HT flit: stay in IDLE; rr_ptr <= winner+1 mod REQ_NUM.
REQ-019 IDLE grant of a HEADER flit: go to LOCKED; owner_id <= winner.
REQ-020 A BODY or TAIL flit offered in IDLE is never eligible; it receives req_ready=0 and is held indefinitely.
REQ-021 LOCKED: req_ready[owner] = enable & req_valid[owner] & on_off_in[req_flit[owner].vc_id]; every other req_ready is 0.
REQ-022 LOCKED: accepting a TAIL flit returns to IDLE with rr_ptr <= owner+1 mod REQ_NUM; BODY keeps LOCKED.
REQ-023 Each accepted flit appears on flit_out with wr_en_out=1 exactly one cycle later; otherwise wr_en_out=0 and flit_out holds its last value.
REQ-024 At most one flit is accepted per cycle; flit order within a packet is preserved, and packets never interleave.
REQ-025 A VC going off mid-packet stalls the owner without releasing the lock.
REQ-026 enable=0 forces all req_ready to 0, sets wr_en_out to 0 on the next edge, and holds the FSM, rr_ptr and owner_id.
REQ-027 rr_ptr wraps from REQ_NUM-1 to 0.

Reset
REQ-028 Reset values: state=IDLE, rr_ptr=0, owner_id=0, wr_en_out=0, flit_out=0, watchdog counter=0, wdog_error=0.
REQ-029 Reset mid-packet abandons the packet; no partial flit is emitted after reset; a later non-HEADER flit is not accepted until a HEADER or HT flit wins arbitration.

Configuration
REQ-030 Macro INJ_ARB_WATCHDOG_EN compiles in the watchdog.
REQ-031 Macro defined: a counter increments on each LOCKED cycle with no acceptance and clears on an acceptance or on leaving LOCKED; when it reaches WDOG_LIMIT, wdog_error is set and stays set until reset; the counter saturates.
REQ-032 Macro undefined: no counter is built, the wdog_error port remains present and is tied to 0.

Verification
REQ-033 After reset, requesters 0 and 2 each hold an HT flit (VC0 on) -> grant order 0 then 2; wr_en_out high in cycles 2 and 3 after release from reset.
REQ-034 Requester 1 sends a HEADER-BODY-TAIL packet while requester 3 presents HEADER -> requester 3 gets ready only in the cycle after the TAIL is accepted; no interleaving on flit_out.
REQ-035 on_off_in[1]=0 for 5 cycles after a VC1 HEADER is accepted -> BODY stalls for 5 cycles, busy stays 1, and other requesters get no ready.
REQ-036 BODY flit offered in IDLE -> req_ready stays 0 for 20 cycles and wr_en_out stays 0.
REQ-037 With INJ_ARB_WATCHDOG_EN and WDOG_LIMIT=8, owner stalls after its HEADER -> wdog_error rises on the 8th stalled cycle and stays high after traffic resumes; without the macro, wdog_error stays 0.
REQ-038 Assert reset while LOCKED mid-packet -> next cycle state is IDLE, wr_en_out is 0 and rr_ptr is 0.
